// File: rtl/trivium_pkg.sv
// Trivium keystream generator: shared constants, FSM state type and the
// single-step state update used by the core.
`timescale 1ns/1ps
package trivium_pkg;

  localparam int unsigned KEY_BYTES  = 10;
  localparam int unsigned IV_BYTES   = 10;
  localparam int unsigned LOAD_BYTES = KEY_BYTES + IV_BYTES;
  localparam int unsigned STATE_W    = 288;

  // Vector bit k holds state bit s(k+1).
  localparam int unsigned IV_BASE = 93;

  localparam int unsigned T1_A = 65,  T1_B = 92,  T1_N0 = 90,  T1_N1 = 91,  T1_C = 170;
  localparam int unsigned T2_A = 161, T2_B = 176, T2_N0 = 174, T2_N1 = 175, T2_C = 263;
  localparam int unsigned T3_A = 242, T3_B = 287, T3_N0 = 285, T3_N1 = 286, T3_C = 68;

  typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} ksg_state_t;

  // One Trivium step: returns {next_state, z}.
  function automatic logic [STATE_W:0] trivium_step(input logic [STATE_W-1:0] s);
    logic t1, t2, t3, z;
    logic [STATE_W-1:0] n;
    t1 = s[T1_A] ^ s[T1_B];
    t2 = s[T2_A] ^ s[T2_B];
    t3 = s[T3_A] ^ s[T3_B];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[T1_N0] & s[T1_N1]) ^ s[T1_C];
    t2 = t2 ^ (s[T2_N0] & s[T2_N1]) ^ s[T2_C];
    t3 = t3 ^ (s[T3_N0] & s[T3_N1]) ^ s[T3_C];
    // Each of the three registers shifts up by one; feedback enters at its base.
    n = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    return {n, z};
  endfunction

endpackage

// File: rtl/trivium_ksg_if.sv
// Load channel and keystream channel between the generator and its user.
`timescale 1ns/1ps
interface trivium_ksg_if;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ks_valid;
  logic       ks_ready;
  logic [7:0] ks_byte;

  modport master (output ld_valid, ld_data, ks_ready,
                  input  ld_ready, ks_valid, ks_byte);
  modport slave  (input  ld_valid, ld_data, ks_ready,
                  output ld_ready, ks_valid, ks_byte);
endinterface

// File: rtl/trivium_byte_buf.sv
// Packs keystream bits LSB first into bytes and holds them in a
// valid/ready output register; stalls the core when both are full.
`timescale 1ns/1ps
module trivium_byte_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       run,
  input  logic       z,
  input  logic       ks_ready,
  output logic       step,
  output logic       ks_valid,
  output logic [7:0] ks_byte
);

  logic [7:0] acc;
  logic [7:0] acc_next;
  logic [2:0] cnt;
  logic       full;
  logic       out_free;

  assign out_free = !ks_valid || ks_ready;
  assign step     = run && (!full || out_free);

  // Accumulator with the current z inserted at the next bit position.
  always_comb begin
    acc_next      = acc;
    acc_next[cnt] = z;
  end

  // Accumulator, bit count and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      full     <= 1'b0;
      ks_valid <= 1'b0;
      ks_byte  <= '0;
    end else if (clear) begin
      acc      <= '0;
      cnt      <= '0;
      full     <= 1'b0;
      ks_valid <= 1'b0;
      ks_byte  <= '0;
    end else begin
      if (ks_valid && ks_ready) ks_valid <= 1'b0;
      if (step) begin
        if (full) begin
          // Held byte moves out; this step's bit starts the next byte.
          ks_byte  <= acc;
          ks_valid <= 1'b1;
          full     <= 1'b0;
          acc      <= {7'd0, z};
          cnt      <= 3'd1;
        end else if (cnt == 3'd7) begin
          cnt <= '0;
          if (out_free) begin
            ks_byte  <= acc_next;
            ks_valid <= 1'b1;
          end else begin
            acc  <= acc_next;
            full <= 1'b1;
          end
        end else begin
          acc <= acc_next;
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/trivium_ksg.sv
// Trivium keystream generator: byte-serial key/IV load, warm-up,
// then keystream bytes through trivium_byte_buf.
`timescale 1ns/1ps
module trivium_ksg
  import trivium_pkg::*;
#(
  parameter int unsigned WARMUP_CYCLES = 1152
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  trivium_ksg_if.slave    bus,
  output logic            busy,
  output logic            keyed
);

  localparam int unsigned WCNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST =
    WCNT_W'((WARMUP_CYCLES == 0) ? 0 : WARMUP_CYCLES - 1);

  ksg_state_t         state;
  logic [STATE_W-1:0] s;
  logic [STATE_W-1:0] s_next;
  logic [STATE_W-1:0] s_loaded;
  logic               z;
  logic [4:0]         ld_cnt;
  logic [WCNT_W-1:0]  wcnt;
  logic               ld_ready_r;
  logic               ld_fire;
  logic               ld_last;
  logic               run;
  logic               buf_step;
  int unsigned        ld_base;

  assign {s_next, z} = trivium_step(s);
  assign run         = (state == RUN);
  assign ld_fire     = bus.ld_valid && ld_ready_r;
  assign ld_last     = (ld_cnt == 5'(LOAD_BYTES - 1));
  assign bus.ld_ready = ld_ready_r;

  // State image after writing the current load byte into its slot.
  always_comb begin
    ld_base = (ld_cnt < 5'(KEY_BYTES)) ? 8 * 32'(ld_cnt)
                                       : IV_BASE + 8 * (32'(ld_cnt) - KEY_BYTES);
    s_loaded = s;
    s_loaded[ld_base +: 8] = bus.ld_data;
    if (ld_last) s_loaded[STATE_W-1 -: 3] = '1;
  end

  // Control FSM with load/warm-up counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      s          <= '0;
      ld_cnt     <= '0;
      wcnt       <= '0;
      ld_ready_r <= 1'b1;
      busy       <= 1'b0;
      keyed      <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      s          <= '0;
      ld_cnt     <= '0;
      wcnt       <= '0;
      ld_ready_r <= 1'b1;
      busy       <= 1'b0;
      keyed      <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (ld_fire) begin
            s <= s_loaded;
            if (ld_last) begin
              ld_cnt     <= '0;
              ld_ready_r <= 1'b0;
              if (WARMUP_CYCLES == 0) begin
                state <= RUN;
                busy  <= 1'b0;
                keyed <= 1'b1;
              end else begin
                state <= WARMUP;
                busy  <= 1'b1;
              end
            end else begin
              ld_cnt <= ld_cnt + 5'd1;
              state  <= LOAD;
              busy   <= 1'b1;
            end
          end
        end
        WARMUP: begin
          s <= s_next;
          if (wcnt == WCNT_LAST) begin
            wcnt  <= '0;
            state <= RUN;
            busy  <= 1'b0;
            keyed <= 1'b1;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end
        RUN: begin
          if (buf_step) s <= s_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

  trivium_byte_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .run      (run),
    .z        (z),
    .ks_ready (bus.ks_ready),
    .step     (buf_step),
    .ks_valid (bus.ks_valid),
    .ks_byte  (bus.ks_byte)
  );

endmodule

// File: tb/tb_trivium_ksg.sv
// Scoreboard bench for trivium_ksg: a bit-level Trivium model fills the
// expected-byte queues, negedge monitors pop and compare on each handshake.
`timescale 1ns/1ps
module tb_trivium_ksg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic busy_a, keyed_a, busy_b, keyed_b;

  always #5 clk = ~clk;

  trivium_ksg_if ifa ();
  trivium_ksg_if ifb ();

  trivium_ksg #(.WARMUP_CYCLES(1152)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifa.slave),
    .busy(busy_a), .keyed(keyed_a)
  );

  trivium_ksg #(.WARMUP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifb.slave),
    .busy(busy_b), .keyed(keyed_b)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] key[10];
  logic [7:0] iv[10];
  int rst_events = 0;

  always @(negedge rst_n) rst_events++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference Trivium over s[1..288]; pushes nbytes LSB-first keystream bytes.
  task automatic model_push(input int which, input int warm, input int nbytes);
    bit s[1:288];
    bit t1, t2, t3, z;
    logic [7:0] b;
    int k;
    b = '0;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 8; j++) begin
        s[8*i + j + 1] = key[i][j];
        s[94 + 8*i + j] = iv[i][j];
      end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int n = 0; n < warm + 8*nbytes; n++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (k = 288; k > 178; k--) s[k] = s[k-1];
      s[178] = t2;
      for (k = 177; k > 94; k--) s[k] = s[k-1];
      s[94] = t1;
      for (k = 93; k > 1; k--) s[k] = s[k-1];
      s[1] = t3;
      if (n >= warm) begin
        b[(n - warm) % 8] = z;
        if ((n - warm) % 8 == 7) begin
          if (which == 0) qa.push_back(b); else qb.push_back(b);
        end
      end
    end
  endtask

  // Monitor for the 1152-warm-up instance, including hold stability.
  logic       hold_a = 1'b0;
  logic [7:0] hold_byte = '0;
  int         hold_ev = 0;
  always @(negedge clk) begin
    if (rst_n && ifa.ks_valid && ifa.ks_ready) begin
      if (qa.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL ks_a_unexpected: actual byte %0h required none", ifa.ks_byte);
      end else begin
        check("ks_a_byte", {24'd0, ifa.ks_byte}, {24'd0, qa.pop_front()});
      end
    end
    if (hold_a && rst_events == hold_ev) begin
      check("ks_a_hold_valid", {31'd0, ifa.ks_valid}, 32'd1);
      check("ks_a_hold_byte", {24'd0, ifa.ks_byte}, {24'd0, hold_byte});
    end
    hold_a    = ifa.ks_valid && !ifa.ks_ready && !clear && rst_n;
    hold_byte = ifa.ks_byte;
    hold_ev   = rst_events;
  end

  // Monitor for the zero-warm-up instance.
  always @(negedge clk) begin
    if (rst_n && ifb.ks_valid && ifb.ks_ready) begin
      if (qb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL ks_b_unexpected: actual byte %0h required none", ifb.ks_byte);
      end else begin
        check("ks_b_byte", {24'd0, ifb.ks_byte}, {24'd0, qb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ld(input int which, input logic v, input logic [7:0] d);
    if (which == 0) begin ifa.ld_valid = v; ifa.ld_data = d; end
    else            begin ifb.ld_valid = v; ifb.ld_data = d; end
  endtask

  task automatic set_ready(input int which, input logic r);
    if (which == 0) ifa.ks_ready = r; else ifb.ks_ready = r;
  endtask

  function automatic int qsize(input int which);
    return (which == 0) ? qa.size() : qb.size();
  endfunction

  // Byte-serial key then IV load with random idle gaps; returns just after
  // the edge that accepted the last byte.
  task automatic load(input int which);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_ld(which, 1'b0, 8'h00);
        tick();
      end
      set_ld(which, 1'b1, (i < 10) ? key[i] : iv[i-10]);
      tick();
    end
    set_ld(which, 1'b0, 8'h00);
  endtask

  task automatic wait_valid(input int which, input int budget, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!((which == 0) ? ifa.ks_valid : ifb.ks_valid) && lat < budget);
  endtask

  task automatic drain(input int which, input int budget, input bit rnd);
    int n = 0;
    while (qsize(which) != 0 && n < budget) begin
      set_ready(which, rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      tick();
      n++;
    end
    check("drain_remaining", qsize(which), 0);
    set_ready(which, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ks_valid"}, {31'd0, ifa.ks_valid}, 32'd0);
    check({tag, "_ld_ready"}, {31'd0, ifa.ld_ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_keyed"}, {31'd0, keyed_a}, 32'd0);
  endtask

  task automatic do_clear();
    set_ready(0, 1'b0);
    set_ready(1, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle("clear");
  endtask

  task automatic rand_key();
    for (int i = 0; i < 10; i++) begin
      key[i] = 8'($urandom);
      iv[i]  = 8'($urandom);
    end
  endtask

  initial begin
    int lat;
    int n;
    bit seen;
    bit ld_checked;
    set_ld(0, 1'b0, 8'h00); set_ld(1, 1'b0, 8'h00);
    set_ready(0, 1'b0);     set_ready(1, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset state and idle behaviour.
    check_idle("reset");
    check("reset_ks_byte", {24'd0, ifa.ks_byte}, 32'd0);
    check("reset_b_ld_ready", {31'd0, ifb.ld_ready}, 32'd1);
    check("reset_b_keyed", {31'd0, keyed_b}, 32'd0);
    set_ready(0, 1'b1); set_ready(1, 1'b1);
    seen = 1'b0;
    repeat (100) begin
      tick();
      seen = seen | ifa.ks_valid | ifb.ks_valid;
    end
    check("idle_ks_valid", {31'd0, seen}, 32'd0);
    set_ready(0, 1'b0); set_ready(1, 1'b0);

    // All-zero key and IV: latency and first 16 bytes.
    for (int i = 0; i < 10; i++) begin key[i] = 8'h00; iv[i] = 8'h00; end
    model_push(0, 1152, 16);
    set_ready(0, 1'b1);
    load(0);
    check("warmup_busy", {31'd0, busy_a}, 32'd1);
    check("warmup_ld_ready", {31'd0, ifa.ld_ready}, 32'd0);
    wait_valid(0, 2000, lat);
    check("latency_warm", lat, 1160);
    check("run_keyed", {31'd0, keyed_a}, 32'd1);
    check("run_busy", {31'd0, busy_a}, 32'd0);
    drain(0, 400, 1'b0);
    do_clear();

    // Key byte 0 = 0x80.
    key[0] = 8'h80;
    model_push(0, 1152, 16);
    set_ready(0, 1'b1);
    load(0);
    drain(0, 2000, 1'b0);
    do_clear();

    // Backpressure: 50 cycles of ks_ready=0 after the first byte.
    rand_key();
    model_push(0, 1152, 16);
    set_ready(0, 1'b1);
    load(0);
    n = 0;
    while (qa.size() > 15 && n < 2000) begin tick(); n++; end
    set_ready(0, 1'b0);
    check("bp_first_byte_seen", qa.size(), 15);
    repeat (50) tick();
    check("bp_no_consumption", qa.size(), 15);
    drain(0, 1000, 1'b1);
    do_clear();

    // Clear at warm-up step 600, then reload the same key/IV.
    load(0);
    repeat (600) tick();
    check("mid_warm_busy", {31'd0, busy_a}, 32'd1);
    do_clear();
    model_push(0, 1152, 16);
    load(0);
    drain(0, 3000, 1'b1);
    do_clear();

    // Asynchronous reset in RUN.
    rand_key();
    model_push(0, 1152, 16);
    load(0);
    n = 0;
    while (qa.size() > 10 && n < 3000) begin
      set_ready(0, $urandom_range(0, 1) != 0);
      tick();
      n++;
    end
    set_ready(0, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_ks_byte", {24'd0, ifa.ks_byte}, 32'd0);
    #2 rst_n = 1'b1;
    qa.delete();
    tick();

    // Load-channel noise during RUN must not disturb the keystream.
    rand_key();
    model_push(0, 1152, 16);
    load(0);
    n = 0;
    ld_checked = 1'b0;
    while (qa.size() != 0 && n < 3000) begin
      if (keyed_a && !ld_checked) begin
        check("run_ld_ready", {31'd0, ifa.ld_ready}, 32'd0);
        ld_checked = 1'b1;
      end
      set_ready(0, $urandom_range(0, 3) != 0);
      if (keyed_a) set_ld(0, 1'($urandom_range(0, 1)), 8'($urandom));
      tick();
      n++;
    end
    set_ld(0, 1'b0, 8'h00);
    check("noise_remaining", qa.size(), 0);
    do_clear();

    // Zero-warm-up instance: latency 8 and keystream straight from load.
    for (int r = 0; r < 3; r++) begin
      rand_key();
      model_push(1, 0, 6);
      set_ready(1, 1'b1);
      load(1);
      wait_valid(1, 100, lat);
      check("latency_nowarm", lat, 8);
      check("nowarm_keyed", {31'd0, keyed_b}, 32'd1);
      drain(1, 300, 1'b1);
      do_clear();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trivium_ksg.md
Name: trivium_ksg

Overview:
- Keystream generator feeding the byte-wide XOR datapath of the trivium_lite top level.
- Accepts an 80-bit key and an 80-bit IV byte-serially, then runs the Trivium warm-up.
- Delivers keystream bytes on a valid/ready interface at one byte per 8 clocks, one state step per clock.
- The downstream XOR stage consumes one byte per plaintext byte, so encrypt and decrypt with the same key/IV produce identical keystream.

Parameters:
- WARMUP_CYCLES, 1152, number of blank state steps after load (4*288); 0 means go straight to RUN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous soft reset, returns to IDLE
- ld_valid  in  1  load byte present
- ld_data  in  8  key bytes 0..9, then IV bytes 0..9
- ld_ready  out  1  load byte accepted when ld_valid & ld_ready
- ks_valid  out  1  keystream byte available
- ks_ready  in  1  consumer takes the byte when ks_valid & ks_ready
- ks_byte  out  8  keystream byte
- busy  out  1  high in LOAD and WARMUP
- keyed  out  1  high in RUN

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset state:
  - IDLE; 288-bit state all zero; load, warm-up and bit counters zero.
  - ks_valid=0, ks_byte=0, ld_ready=1, busy=0, keyed=0.
- clear has the same effect as reset, applied at the next edge. It has priority over every other input in every state, including mid-load and mid-warm-up.
- States:
  - IDLE: the first load handshake moves to LOAD.
  - LOAD: the 20th accepted byte moves to WARMUP, or to RUN if WARMUP_CYCLES=0.
  - WARMUP: advances after exactly WARMUP_CYCLES steps.
  - RUN: remains until clear or reset.
- ld_ready is 1 in IDLE and LOAD, 0 otherwise. ld_valid outside IDLE/LOAD is ignored; rekeying requires clear.
- Load mapping (state bits numbered s1..s288):
  - Key byte i, bit j -> s(8i+j+1), for s1..s80.
  - IV byte i, bit j -> s(94+8i+j), for s94..s173.
  - At the edge accepting byte 19: s286=s287=s288=1, and all other unloaded bits are 0.
- One step, all terms XOR (^) except & (AND):
  - t1=s66^s93; t2=s162^s177; t3=s243^s288; z=t1^t2^t3.
  - t1^=s91&s92^s171; t2^=s175&s176^s264; t3^=s286&s287^s69.
  - s1..s93 <= {t3, s1..s92}; s94..s177 <= {t1, s94..s176}; s178..s288 <= {t2, s178..s287}.
- WARMUP: one step per clock; z is discarded.
- RUN:
  - Bit packing: the first z of each byte goes to ks_byte bit0, LSB first.
  - 8-bit accumulator with a 3-bit count. The core steps every clock in which the accumulator is not full, or in which it is full and the output register is being freed.
  - When the 8th bit is complete, the byte transfers to ks_byte at that edge if ks_valid=0 or ks_ready=1 in that cycle.
  - If the output register is full and not consumed, the accumulator holds its full byte and the core stalls. No step occurs and no keystream bit is skipped or duplicated.
- Latency: ks_valid rises at the (WARMUP_CYCLES+8)th rising edge after the edge that accepted ld byte 19.
- Throughput: under continuous ks_ready=1, ks_valid pulses with 1 cycle high per 8 cycles.
- ks_byte is stable while ks_valid=1 and ks_ready=0.

Decomposition:
- Package trivium_pkg:
  - Constants: KEY_BYTES=10, IV_BYTES=10, STATE_W=288.
  - Tap index constants.
  - Enum ksg_state_t {IDLE, LOAD, WARMUP, RUN}.
  - A pure function trivium_step(state) returning {next_state, z}.
- Natural sub-module: trivium_byte_buf, the accumulator plus output register and handshake. The FSM and counters live in trivium_ksg.

Test Plan:
- Reset and idle: after rst_n release, outputs are ks_valid=0, ld_ready=1, busy=0, keyed=0. Drive ks_ready=1 for 100 cycles -> ks_valid stays 0.
- Golden vector: key=00..00, IV=00..00, WARMUP_CYCLES=1152, ks_ready=1.
  - ks_valid first high exactly 1160 edges after the last load.
  - First 16 bytes match the bench Trivium model with LSB-first packing.
  - Repeat with key bytes 0x80,0x00..0x00 against the model.
- Backpressure: hold ks_ready=0 for 50 cycles after the first byte.
  - ks_byte is unchanged and no step occurs while the accumulator is full.
  - On release, the byte sequence equals the no-stall sequence.
- Clear mid-warm-up (at step 600) -> IDLE next cycle and ks_valid=0. Reloading the same key/IV then yields a byte stream identical to the golden run.
- Async reset mid-RUN (rst_n low for 3 ns between edges) -> outputs return to reset values immediately. ld_valid while keyed=1 is ignored, and the keystream is unaffected.
- WARMUP_CYCLES=0 build: ks_valid is high 8 edges after the last load, and the byte equals the model's first 8 z bits with no warm-up.
